alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl_pkg.sv | 31 +++
 rtl/alu_issue_ctrl_funct_decode.sv | 35 +++
 rtl/alu_issue_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: shared funct codes, ALU control codes and FSM encoding
// for the ALU issue controller and its funct decoder.
package alu_issue_ctrl_pkg;

    // MIPS R-type funct codes accepted by the controller
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;

    // ALU control codes; 3'b011 is reserved and never issued
    localparam logic [2:0] CTR_ADDU = 3'b000;
    localparam logic [2:0] CTR_ADD  = 3'b001;
    localparam logic [2:0] CTR_OR   = 3'b010;
    localparam logic [2:0] CTR_SUBU = 3'b100;
    localparam logic [2:0] CTR_SUB  = 3'b101;
    localparam logic [2:0] CTR_SLTU = 3'b110;
    localparam logic [2:0] CTR_SLT  = 3'b111;

    localparam int STAT_W = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_funct_decode.sv
// funct_decode: combinational funct -> {ALU control, legal, overflow-check}.
// Only the signed add/sub forms report overflow; every other op masks it.
module funct_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctr,
    output logic       legal,
    output logic       ovf_check
);

    // Table lookup of the seven supported R-type ops
    always_comb begin
        alu_ctr   = CTR_ADDU;
        legal     = 1'b1;
        ovf_check = 1'b0;
        case (funct)
            FUNCT_ADDU: alu_ctr = CTR_ADDU;
            FUNCT_ADD: begin
                alu_ctr   = CTR_ADD;
                ovf_check = 1'b1;
            end
            FUNCT_OR:   alu_ctr = CTR_OR;
            FUNCT_SUBU: alu_ctr = CTR_SUBU;
            FUNCT_SUB: begin
                alu_ctr   = CTR_SUB;
                ovf_check = 1'b1;
            end
            FUNCT_SLTU: alu_ctr = CTR_SLTU;
            FUNCT_SLT:  alu_ctr = CTR_SLT;
            default:    legal   = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one R-type request at a time, drives a combinational
// ALU from registered operands for one cycle, and returns the captured result
// through a valid/ready response port. Illegal funct codes bypass the ALU and
// respond one cycle earlier with rsp_illegal set.
// Optional build macro ALU_ISSUE_STATS_EN adds stat_ops / stat_ovf counters.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [5:0]   req_funct,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    output logic [N-1:0] alu_A,
    output logic [N-1:0] alu_B,
    output logic [2:0]   alu_ALUctr,
    input  logic [N-1:0] alu_Result,
    input  logic         alu_Zero,
    input  logic         alu_Overflow,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_zero,
    output logic         rsp_ovf,
    output logic         rsp_illegal
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_ops,
    output logic [STAT_W-1:0] stat_ovf
`endif
);

    state_t state_q, state_d;

    logic [2:0] dec_ctr;
    logic       dec_legal;
    logic       dec_ovf_check;
    logic       ovf_check_q;

    logic accept_legal;
    logic accept_illegal;
    logic capture;
    logic rsp_hs;

    funct_decode u_dec (
        .funct     (req_funct),
        .alu_ctr   (dec_ctr),
        .legal     (dec_legal),
        .ovf_check (dec_ovf_check)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state, handshake outputs and datapath enables
    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        accept_legal   = 1'b0;
        accept_illegal = 1'b0;
        capture        = 1'b0;
        rsp_hs         = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept_legal   = dec_legal;
                    accept_illegal = !dec_legal;
                    state_d        = dec_legal ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: begin
                capture = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_hs  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ALU operand registers: loaded only on a legal accept, held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_A       <= '0;
            alu_B       <= '0;
            alu_ALUctr  <= CTR_ADDU;
            ovf_check_q <= 1'b0;
        end else if (accept_legal) begin
            alu_A       <= req_a;
            alu_B       <= req_b;
            alu_ALUctr  <= dec_ctr;
            ovf_check_q <= dec_ovf_check;
        end
    end

    // Response registers: ALU sample at the end of ISSUE, or the illegal
    // marker on an illegal accept; held through RESP until the handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_ovf     <= 1'b0;
            rsp_illegal <= 1'b0;
        end else if (capture) begin
            rsp_result  <= alu_Result;
            rsp_zero    <= alu_Zero;
            rsp_ovf     <= alu_Overflow & ovf_check_q;
            rsp_illegal <= 1'b0;
        end else if (accept_illegal) begin
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_ovf     <= 1'b0;
            rsp_illegal <= 1'b1;
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    // Wrapping counters of completed responses and overflowing responses
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops <= '0;
            stat_ovf <= '0;
        end else if (rsp_hs) begin
            stat_ops <= stat_ops + 1'b1;
            if (rsp_ovf) stat_ovf <= stat_ovf + 1'b1;
        end
    end
`endif

endmodule
